// File: rtl/dct_transpose_buffer_if.sv
// Stream bundle for the DCT transpose buffer.
// Sample input, read-order select and sample output with handshakes.
interface dct_transpose_buffer_if #(
    parameter int D_WIDTH = 13
);
    logic               in_valid;
    logic               in_ready;
    logic [D_WIDTH-1:0] in_data;
    logic               transpose_en;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_data;
    logic               out_last;

    modport slave (
        input  in_valid,
        input  in_data,
        input  transpose_en,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

    modport master (
        output in_valid,
        output in_data,
        output transpose_en,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/dct_transpose_buffer.sv
// Ping-pong N x N block buffer with raster or transposed read-out.
// Two banks in one dual-port RAM; reads pass a RAM and an output stage.
module dct_transpose_buffer #(
    parameter int D_WIDTH = 13,
    parameter int N       = 8
) (
    input  logic               clock,
    input  logic               reset,
    dct_transpose_buffer_if.slave bus
);
    localparam int LW    = $clog2(N);
    localparam int PW    = 2 * LW;
    localparam int AW    = PW + 1;
    localparam int DEPTH = 2 * N * N;

    logic [D_WIDTH-1:0] mem [DEPTH];

    logic [1:0]         full;
    logic [1:0]         full_d;
    logic [1:0]         mode;
    logic               wbank;
    logic               rbank;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;

    logic               wr_en;
    logic               rd_en;
    logic               adv;
    logic               w_end;
    logic               r_end;
    logic [LW-1:0]      ri;
    logic [LW-1:0]      ro;
    logic [LW-1:0]      rrow;
    logic [LW-1:0]      rcol;
    logic [AW-1:0]      waddr;
    logic [AW-1:0]      raddr;

    logic [D_WIDTH-1:0] dout;
    logic               dout_v;
    logic               dout_last;
    logic               out_valid_q;
    logic               out_last_q;
    logic [D_WIDTH-1:0] out_data_q;

    assign bus.in_ready  = !full[wbank] && !reset;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;

    assign wr_en = bus.in_valid && bus.in_ready;
    assign w_end = &wptr;
    assign waddr = {wbank, wptr};

    // The whole read pipeline moves only when the output stage is free.
    assign adv   = !out_valid_q || bus.out_ready;
    assign rd_en = full[rbank] && adv;
    assign r_end = &rptr;

    // ri is the fast read index; it walks rows in transpose mode.
    assign ri    = rptr[LW-1:0];
    assign ro    = rptr[PW-1:LW];
    assign rrow  = mode[rbank] ? ri : ro;
    assign rcol  = mode[rbank] ? ro : ri;
    assign raddr = {rbank, rrow, rcol};

    // Bank fill flags: a write-side set and a read-side clear can coincide.
    always_comb begin
        full_d = full;
        if (wr_en && w_end)
            full_d[wbank] = 1'b1;
        if (rd_en && r_end)
            full_d[rbank] = 1'b0;
    end

    // Sample RAM with registered read port.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[waddr] <= bus.in_data;
        if (rd_en)
            dout <= mem[raddr];
    end

    // Write side: counters, bank select and per-bank read mode.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            wbank <= 1'b0;
            mode  <= '0;
        end else if (wr_en) begin
            wptr <= wptr + PW'(1);
            if (wptr == '0)
                mode[wbank] <= bus.transpose_en;
            if (w_end)
                wbank <= !wbank;
        end
    end

    // Read side: counters, bank select and fill flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            rptr  <= '0;
            rbank <= 1'b0;
            full  <= '0;
        end else begin
            full <= full_d;
            if (rd_en) begin
                rptr <= rptr + PW'(1);
                if (r_end)
                    rbank <= !rbank;
            end
        end
    end

    // Output pipeline: RAM stage then output stage, stalled together.
    always_ff @(posedge clock) begin
        if (reset) begin
            dout_v      <= 1'b0;
            dout_last   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            dout_v      <= rd_en;
            dout_last   <= rd_en && r_end;
            out_valid_q <= dout_v;
            out_last_q  <= dout_v && dout_last;
            if (dout_v)
                out_data_q <= dout;
        end
    end
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer: directed tables plus randomized streams.
// Outputs are scored against a block-level reference model.
module tb_dct_transpose_buffer;
    localparam int DW = 13;
    localparam int N  = 8;
    localparam int NN = N * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dct_transpose_buffer_if #(.D_WIDTH(DW)) bus();

    dct_transpose_buffer #(.D_WIDTH(DW), .N(N)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    typedef struct {
        int            test;
        int            pos;
        logic [DW-1:0] exp;
        string         nm;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DW-1:0] tx_d[$];
    logic          tx_m[$];
    exp_t          exp_q[$];
    logic [DW-1:0] got_d[$];
    logic          got_l[$];
    logic [DW-1:0] blk[NN];
    int            acc = 0;
    logic          bmode = 1'b0;
    int            acc_total = 0;
    int            last_acc_cyc = 0;
    int            first_valid_cyc = 0;
    logic          seen_valid = 1'b0;
    int            idle_cnt = 0;
    logic          count_idle = 1'b0;
    int            rdy_mode = 1;
    logic          held_v = 1'b0;
    logic [DW-1:0] held_d;
    logic          held_l;
    exp_t          e;
    vec_t          vt[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Driver: inputs change 1 time unit after each rising edge.
    initial begin
        bus.in_valid     = 1'b0;
        bus.in_data      = '0;
        bus.transpose_en = 1'b0;
        bus.out_ready    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tx_d.size() > 0 && !rst) begin
                bus.in_valid     = 1'b1;
                bus.in_data      = tx_d[0];
                bus.transpose_en = tx_m[0];
            end else begin
                bus.in_valid = 1'b0;
            end
            case (rdy_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor and reference model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                acc = 0;
                exp_q.delete();
                held_v = 1'b0;
                continue;
            end
            if (bus.out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                first_valid_cyc = cyc;
            end
            if (count_idle && seen_valid && exp_q.size() > 0
                && !bus.out_valid)
                idle_cnt++;
            if (held_v) begin
                chk("stall_valid", 32'(bus.out_valid), 1);
                chk("stall_data", 32'(bus.out_data), 32'(held_d));
                chk("stall_last", 32'(bus.out_last), 32'(held_l));
            end
            held_v = bus.out_valid && !bus.out_ready;
            held_d = bus.out_data;
            held_l = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                got_d.push_back(bus.out_data);
                got_l.push_back(bus.out_last);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0d expected none",
                             bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(bus.out_data), 32'(e.d));
                    chk("out_last", 32'(bus.out_last), 32'(e.l));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                if (acc == 0)
                    bmode = bus.transpose_en;
                blk[acc] = bus.in_data;
                acc++;
                acc_total++;
                last_acc_cyc = cyc + 1;
                void'(tx_d.pop_front());
                void'(tx_m.pop_front());
                if (acc == NN) begin
                    for (int i = 0; i < NN; i++) begin
                        e.d = bmode ? blk[(i % N) * N + i / N] : blk[i];
                        e.l = (i == NN - 1);
                        exp_q.push_back(e);
                    end
                    acc = 0;
                end
            end
        end
    end

    task automatic start_test();
        got_d.delete();
        got_l.delete();
        seen_valid = 1'b0;
        acc_total  = 0;
        idle_cnt   = 0;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #2;
        rst = 1'b1;
        tx_d.delete();
        tx_m.delete();
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_last", 32'(bus.out_last), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    endtask

    task automatic wait_acc(input int n, input int budget);
        int k;
        k = 0;
        while (acc_total < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (acc_total < n) begin
            checks++;
            errors++;
            $display("FAIL timeout_accept: got %0d expected %0d",
                     acc_total, n);
        end
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((tx_d.size() > 0 || acc != 0 || exp_q.size() > 0)
               && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (tx_d.size() > 0 || acc != 0 || exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL timeout_drain: pending %0d tx %0d out",
                     tx_d.size(), exp_q.size());
        end
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic apply_table(input int test);
        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].test == test) begin
                if (vt[i].pos < got_d.size())
                    chk(vt[i].nm, 32'(got_d[vt[i].pos]), 32'(vt[i].exp));
                else
                    chk({vt[i].nm, "_missing"}, got_d.size(), vt[i].pos + 1);
            end
        end
    endtask

    task automatic push_rand(input int nblk, input int mode_sel);
        for (int b = 0; b < nblk; b++) begin
            logic m;
            if (mode_sel == 2)
                m = 1'($urandom_range(0, 1));
            else
                m = (b % 2 == 0) ? 1'b1 : 1'b0;
            for (int i = 0; i < NN; i++) begin
                tx_d.push_back(DW'($urandom));
                tx_m.push_back(m);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones;
        logic [DW-1:0] v0;

        vt.push_back('{1, 0,  13'd0,  "t_pos0"});
        vt.push_back('{1, 1,  13'd8,  "t_pos1"});
        vt.push_back('{1, 7,  13'd56, "t_pos7"});
        vt.push_back('{1, 8,  13'd1,  "t_pos8"});
        vt.push_back('{1, 9,  13'd9,  "t_pos9"});
        vt.push_back('{1, 62, 13'd55, "t_pos62"});
        vt.push_back('{1, 63, 13'd63, "t_pos63"});
        vt.push_back('{2, 0,  13'd0,  "r_pos0"});
        vt.push_back('{2, 1,  13'd1,  "r_pos1"});
        vt.push_back('{2, 8,  13'd8,  "r_pos8"});
        vt.push_back('{2, 63, 13'd63, "r_pos63"});
        vt.push_back('{3, 8,  13'h1000, "neg_full_scale"});
        vt.push_back('{3, 55, 13'h0FFF, "pos_full_scale"});

        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        rst = 1'b0;

        start_test();
        for (int i = 0; i < NN; i++) begin
            tx_d.push_back(DW'(i));
            tx_m.push_back(1'b1);
        end
        wait_drain(400);
        chk("t_count", got_d.size(), NN);
        chk("t_latency", first_valid_cyc - last_acc_cyc, 2);
        ones = 0;
        foreach (got_l[i]) ones += int'(got_l[i]);
        chk("t_last_count", ones, 1);
        if (got_l.size() == NN)
            chk("t_last_pos", 32'(got_l[NN-1]), 1);
        apply_table(1);

        start_test();
        for (int i = 0; i < NN; i++) begin
            tx_d.push_back(DW'(i));
            tx_m.push_back(i == 0 ? 1'b0 : 1'b1);
        end
        wait_drain(400);
        chk("r_count", got_d.size(), NN);
        apply_table(2);

        start_test();
        for (int i = 0; i < NN; i++) begin
            if (i == 1)
                tx_d.push_back(13'h1000);
            else if (i == 62)
                tx_d.push_back(13'h0FFF);
            else
                tx_d.push_back(DW'($urandom));
            tx_m.push_back(1'b1);
        end
        wait_drain(400);
        apply_table(3);

        start_test();
        rdy_mode = 0;
        push_rand(3, 0);
        repeat (250) @(posedge clk);
        #2;
        chk("bp_accepted", acc_total, 2 * NN);
        chk("bp_in_ready", 32'(bus.in_ready), 0);
        rdy_mode = 2;
        wait_drain(3000);
        chk("bp_count", got_d.size(), 3 * NN);

        start_test();
        rdy_mode = 1;
        count_idle = 1'b1;
        push_rand(10, 2);
        wait_drain(2000);
        count_idle = 1'b0;
        chk("stream_count", got_d.size(), 10 * NN);
        chk("stream_idle_ok", 32'(idle_cnt <= 2 * 10), 1);

        start_test();
        for (int i = 0; i < 40; i++) begin
            tx_d.push_back(DW'($urandom));
            tx_m.push_back(1'b1);
        end
        wait_acc(20, 200);
        do_reset(1);
        start_test();
        v0 = DW'($urandom);
        tx_d.push_back(v0);
        tx_m.push_back(1'b1);
        for (int i = 1; i < NN; i++) begin
            tx_d.push_back(DW'($urandom));
            tx_m.push_back(1'b1);
        end
        wait_drain(400);
        chk("mid_rst_count", got_d.size(), NN);
        if (got_d.size() > 0)
            chk("mid_rst_first", 32'(got_d[0]), 32'(v0));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
